// File: rtl/button_conditioner_if.sv
// -----------------------------------------------------------------------------
// button_conditioner_if
// Bundles the per-channel button signals between the pads/testbench and the
// button conditioner.
//   button_i  : raw pin levels, asynchronous to the conditioner clock
//   state_o   : debounced level, 1 = pressed
//   press_o   : one-clock pulse on a debounced press
//   release_o : one-clock pulse on a debounced release
//   long_o    : one-clock pulse when a press has been held LONG_CYCLES
//   repeat_o  : one-clock auto-repeat pulses after a long press
// Modports: master drives the pins and observes events, slave is the
// conditioner itself.
// -----------------------------------------------------------------------------
interface button_conditioner_if #(
    parameter int NUM_BUTTONS = 3
);
    logic [NUM_BUTTONS-1:0] button_i;
    logic [NUM_BUTTONS-1:0] state_o;
    logic [NUM_BUTTONS-1:0] press_o;
    logic [NUM_BUTTONS-1:0] release_o;
    logic [NUM_BUTTONS-1:0] long_o;
    logic [NUM_BUTTONS-1:0] repeat_o;

    modport master (
        output button_i,
        input  state_o, press_o, release_o, long_o, repeat_o
    );

    modport slave (
        input  button_i,
        output state_o, press_o, release_o, long_o, repeat_o
    );
endinterface

// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
// N-channel push-button conditioner: per channel a two-flop synchroniser with
// selectable polarity, a counter debouncer, press/release edge pulses and
// long-press detection. Optional auto-repeat after a long press is compiled in
// with the BUTTON_REPEAT_EN macro; without it repeat_o is tied low.
//
// Ports (top):
//   clk      : system clock, rising edge
//   reset_i  : synchronous active-high reset
//   bus      : button_conditioner_if.slave (button_i in; state_o, press_o,
//              release_o, long_o, repeat_o out, all NUM_BUTTONS wide)
//
// Ports (button_conditioner_ch, one per channel):
//   i_clk, i_rst : clock / synchronous reset
//   i_pin        : raw pin level
//   o_state, o_press, o_release, o_long, o_repeat : conditioned outputs
// -----------------------------------------------------------------------------

module button_conditioner_ch #(
    parameter bit ACTIVE_LOW      = 1'b1,
    parameter int DEBOUNCE_CYCLES = 120_000,
    parameter int LONG_CYCLES     = 12_000_000,
    parameter int REPEAT_CYCLES   = 2_400_000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_pin,
    output logic o_state,
    output logic o_press,
    output logic o_release,
    output logic o_long,
    output logic o_repeat
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HW = $clog2(LONG_CYCLES + 1);

    localparam logic          REL_LVL   = ACTIVE_LOW;
    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_FIRE = HW'(LONG_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_CYCLES);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_state;
    logic          r_press;
    logic          r_release;
    logic          r_long;
    logic [DW-1:0] r_db_cnt;
    logic [HW-1:0] r_hold;

    logic w_raw;
    logic w_diff;
    logic w_toggle;
    logic w_long_hit;

    // raw = 1 means pressed regardless of pin polarity
    assign w_raw      = r_sync2 ^ REL_LVL;
    assign w_diff     = (w_raw != r_state);
    // this clock would bring the count to DEBOUNCE_CYCLES: accept the new level
    assign w_toggle   = w_diff && (r_db_cnt == DB_LAST);
    // a release on the same edge wins over the long-press pulse
    assign w_long_hit = r_state && !w_toggle && (r_hold == HOLD_FIRE);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1   <= REL_LVL;
            r_sync2   <= REL_LVL;
            r_state   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_long    <= 1'b0;
            r_db_cnt  <= '0;
            r_hold    <= '0;
        end else begin
            r_sync1 <= i_pin;
            r_sync2 <= r_sync1;

            if (!w_diff || w_toggle)
                r_db_cnt <= '0;
            else
                r_db_cnt <= r_db_cnt + 1'b1;

            if (w_toggle)
                r_state <= ~r_state;

            r_press   <= w_toggle && !r_state;
            r_release <= w_toggle &&  r_state;

            // saturates at LONG_CYCLES so HOLD_FIRE is seen once per press
            if (!r_state)
                r_hold <= '0;
            else if (r_hold != HOLD_MAX)
                r_hold <= r_hold + 1'b1;

            r_long <= w_long_hit;
        end
    end

    assign o_state   = r_state;
    assign o_press   = r_press;
    assign o_release = r_release;
    assign o_long    = r_long;

`ifdef BUTTON_REPEAT_EN
    localparam int            RW       = $clog2(REPEAT_CYCLES + 1);
    localparam logic [RW-1:0] RPT_LAST = RW'(REPEAT_CYCLES - 1);

    logic          r_rpt_act;
    logic [RW-1:0] r_rpt_cnt;
    logic          r_repeat;

    // Counter is 0 in the cycle long_o is high, so the first repeat lands
    // REPEAT_CYCLES clocks later; it wraps for the following ones.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rpt_act <= 1'b0;
            r_rpt_cnt <= '0;
            r_repeat  <= 1'b0;
        end else if (w_long_hit) begin
            r_rpt_act <= 1'b1;
            r_rpt_cnt <= '0;
            r_repeat  <= 1'b0;
        end else if (!r_state || w_toggle) begin
            // released (or releasing on this edge): stop immediately
            r_rpt_act <= 1'b0;
            r_rpt_cnt <= '0;
            r_repeat  <= 1'b0;
        end else if (r_rpt_act) begin
            r_repeat  <= (r_rpt_cnt == RPT_LAST);
            r_rpt_cnt <= (r_rpt_cnt == RPT_LAST) ? '0 : r_rpt_cnt + 1'b1;
        end else begin
            r_repeat  <= 1'b0;
        end
    end

    assign o_repeat = r_repeat;
`else
    // Keeps REPEAT_CYCLES referenced when the repeat counter is compiled
    // out; drives nothing.
    logic w_unused_repeat;
    assign w_unused_repeat = ^REPEAT_CYCLES;
    assign o_repeat        = 1'b0;
`endif

endmodule

module button_conditioner #(
    parameter int NUM_BUTTONS     = 3,
    parameter bit ACTIVE_LOW      = 1'b1,
    parameter int DEBOUNCE_CYCLES = 120_000,
    parameter int LONG_CYCLES     = 12_000_000,
    parameter int REPEAT_CYCLES   = 2_400_000
) (
    input  logic                clk,
    input  logic                reset_i,
    button_conditioner_if.slave bus
);
    logic [NUM_BUTTONS-1:0] w_state;
    logic [NUM_BUTTONS-1:0] w_press;
    logic [NUM_BUTTONS-1:0] w_release;
    logic [NUM_BUTTONS-1:0] w_long;
    logic [NUM_BUTTONS-1:0] w_repeat;

    genvar g;
    generate
        for (g = 0; g < NUM_BUTTONS; g++) begin : g_ch
            button_conditioner_ch #(
                .ACTIVE_LOW      (ACTIVE_LOW),
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .LONG_CYCLES     (LONG_CYCLES),
                .REPEAT_CYCLES   (REPEAT_CYCLES)
            ) u_ch (
                .i_clk     (clk),
                .i_rst     (reset_i),
                .i_pin     (bus.button_i[g]),
                .o_state   (w_state[g]),
                .o_press   (w_press[g]),
                .o_release (w_release[g]),
                .o_long    (w_long[g]),
                .o_repeat  (w_repeat[g])
            );
        end
    endgenerate

    assign bus.state_o   = w_state;
    assign bus.press_o   = w_press;
    assign bus.release_o = w_release;
    assign bus.long_o    = w_long;
    assign bus.repeat_o  = w_repeat;

endmodule

// File: tb/tb_button_conditioner.sv
module tb_button_conditioner;
    logic clk;
    logic reset_i;
    int   checks;
    int   errors;

    button_conditioner_if #(.NUM_BUTTONS(3)) bus ();

    button_conditioner #(
        .NUM_BUTTONS     (3),
        .ACTIVE_LOW      (1'b1),
        .DEBOUNCE_CYCLES (4),
        .LONG_CYCLES     (10),
        .REPEAT_CYCLES   (3)
    ) dut (
        .clk     (clk),
        .reset_i (reset_i),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        logic [14:0] obs;
        reset_i      = 1'b1;
        bus.button_i = 3'b111;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            @(negedge clk);
            obs = {bus.state_o, bus.press_o, bus.release_o, bus.long_o, bus.repeat_o};
            checks++;
            if (obs !== 15'b0) begin
                errors++;
                $display("FAIL reset_hold k=%0d got %b exp 0", k, obs);
            end
        end
        reset_i = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            @(negedge clk);
            obs = {bus.state_o, bus.press_o, bus.release_o, bus.long_o, bus.repeat_o};
            checks++;
            if (obs !== 15'b0) begin
                errors++;
                $display("FAIL reset_idle k=%0d got %b exp 0", k, obs);
            end
        end
    endtask

    task automatic test_press;
        bus.button_i = 3'b110;
        for (int k = 0; k < 9; k++) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (bus.state_o[0] !== (k >= 5)) begin
                errors++;
                $display("FAIL press_state k=%0d got %b exp %b", k, bus.state_o[0], (k >= 5));
            end
            checks++;
            if (bus.press_o[0] !== (k == 5)) begin
                errors++;
                $display("FAIL press_pulse k=%0d got %b exp %b", k, bus.press_o[0], (k == 5));
            end
            checks++;
            if ({bus.state_o[2:1], bus.press_o[2:1]} !== 4'b0) begin
                errors++;
                $display("FAIL press_others k=%0d got %b exp 0000", k,
                         {bus.state_o[2:1], bus.press_o[2:1]});
            end
        end
        bus.button_i = 3'b111;
        idle_cycles(12);
    endtask

    task automatic test_glitch;
        for (int r = 0; r < 5; r++) begin
            for (int s = 0; s < 4; s++) begin
                bus.button_i[1] = (s == 3);
                @(posedge clk);
                @(negedge clk);
                checks++;
                if ({bus.state_o[1], bus.press_o[1], bus.release_o[1]} !== 3'b0) begin
                    errors++;
                    $display("FAIL glitch r=%0d s=%0d got %b exp 000", r, s,
                             {bus.state_o[1], bus.press_o[1], bus.release_o[1]});
                end
            end
        end
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if ({bus.state_o[1], bus.press_o[1], bus.release_o[1]} !== 3'b0) begin
                errors++;
                $display("FAIL glitch_tail k=%0d got %b exp 000", k,
                         {bus.state_o[1], bus.press_o[1], bus.release_o[1]});
            end
        end
    endtask

    task automatic test_long;
        logic exp_rpt;
        bus.button_i[2] = 1'b0;
        for (int k = 0; k <= 40; k++) begin
            @(posedge clk);
            @(negedge clk);
`ifdef BUTTON_REPEAT_EN
            exp_rpt = (k >= 18) && (k <= 33) && (((k - 18) % 3) == 0);
`else
            exp_rpt = 1'b0;
`endif
            checks++;
            if (bus.state_o[2] !== ((k >= 5) && (k < 35))) begin
                errors++;
                $display("FAIL long_state k=%0d got %b exp %b", k, bus.state_o[2],
                         ((k >= 5) && (k < 35)));
            end
            checks++;
            if (bus.press_o[2] !== (k == 5)) begin
                errors++;
                $display("FAIL long_press k=%0d got %b exp %b", k, bus.press_o[2], (k == 5));
            end
            checks++;
            if (bus.long_o[2] !== (k == 15)) begin
                errors++;
                $display("FAIL long_pulse k=%0d got %b exp %b", k, bus.long_o[2], (k == 15));
            end
            checks++;
            if (bus.release_o[2] !== (k == 35)) begin
                errors++;
                $display("FAIL long_release k=%0d got %b exp %b", k, bus.release_o[2], (k == 35));
            end
            checks++;
            if (bus.repeat_o[2] !== exp_rpt) begin
                errors++;
                $display("FAIL long_repeat k=%0d got %b exp %b", k, bus.repeat_o[2], exp_rpt);
            end
            if (k == 29) bus.button_i[2] = 1'b1;
        end
        idle_cycles(5);
    endtask

    // Release lands on the very edge where long_o would be produced.
    task automatic test_release_vs_long;
        bus.button_i[1] = 1'b0;
        for (int k = 0; k <= 20; k++) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (bus.long_o[1] !== 1'b0) begin
                errors++;
                $display("FAIL rvl_long k=%0d got %b exp 0", k, bus.long_o[1]);
            end
            checks++;
            if (bus.release_o[1] !== (k == 15)) begin
                errors++;
                $display("FAIL rvl_release k=%0d got %b exp %b", k, bus.release_o[1], (k == 15));
            end
            checks++;
            if (bus.state_o[1] !== ((k >= 5) && (k < 15))) begin
                errors++;
                $display("FAIL rvl_state k=%0d got %b exp %b", k, bus.state_o[1],
                         ((k >= 5) && (k < 15)));
            end
            if (k == 9) bus.button_i[1] = 1'b1;
        end
        idle_cycles(5);
    endtask

    task automatic test_simultaneous;
        logic [2:0] exp_st;
        logic [2:0] exp_pr;
        logic [2:0] exp_rl;
        bus.button_i = 3'b000;
        for (int k = 0; k <= 16; k++) begin
            @(posedge clk);
            @(negedge clk);
            exp_st = ((k >= 5) && (k < 13)) ? 3'b111 : 3'b000;
            exp_pr = (k == 5)  ? 3'b111 : 3'b000;
            exp_rl = (k == 13) ? 3'b111 : 3'b000;
            checks++;
            if (bus.state_o !== exp_st) begin
                errors++;
                $display("FAIL simul_state k=%0d got %b exp %b", k, bus.state_o, exp_st);
            end
            checks++;
            if (bus.press_o !== exp_pr) begin
                errors++;
                $display("FAIL simul_press k=%0d got %b exp %b", k, bus.press_o, exp_pr);
            end
            checks++;
            if (bus.release_o !== exp_rl) begin
                errors++;
                $display("FAIL simul_release k=%0d got %b exp %b", k, bus.release_o, exp_rl);
            end
            checks++;
            if (bus.long_o !== 3'b000) begin
                errors++;
                $display("FAIL simul_long k=%0d got %b exp 000", k, bus.long_o);
            end
            if (k == 7) bus.button_i = 3'b111;
        end
        idle_cycles(5);
    endtask

    task automatic test_reset_mid_press;
        bus.button_i[0] = 1'b0;
        idle_cycles(8);
        checks++;
        if (bus.state_o[0] !== 1'b1) begin
            errors++;
            $display("FAIL rmp_pre_state got %b exp 1", bus.state_o[0]);
        end
        reset_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bus.state_o, bus.press_o, bus.release_o} !== 9'b0) begin
            errors++;
            $display("FAIL rmp_in_reset got %b exp 0",
                     {bus.state_o, bus.press_o, bus.release_o});
        end
        reset_i = 1'b0;
        for (int k = 0; k <= 10; k++) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (bus.state_o[0] !== (k >= 5)) begin
                errors++;
                $display("FAIL rmp_state k=%0d got %b exp %b", k, bus.state_o[0], (k >= 5));
            end
            checks++;
            if (bus.press_o[0] !== (k == 5)) begin
                errors++;
                $display("FAIL rmp_press k=%0d got %b exp %b", k, bus.press_o[0], (k == 5));
            end
            checks++;
            if (bus.release_o !== 3'b000) begin
                errors++;
                $display("FAIL rmp_release k=%0d got %b exp 000", k, bus.release_o);
            end
        end
        bus.button_i = 3'b111;
        idle_cycles(10);
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        reset_i      = 1'b1;
        bus.button_i = 3'b111;
        @(negedge clk);
        test_reset();
        test_press();
        test_glitch();
        test_long();
        test_release_vs_long();
        test_simultaneous();
        test_reset_mid_press();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
